// File: rtl/voxel_edit_scheduler_if.sv
// Host edit request channel into the voxel edit scheduler.
// The host is the master; the scheduler is the slave and owns edit_ready.
interface voxel_edit_scheduler_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 64
);
  logic              edit_valid;
  logic              edit_ready;
  logic [ADDR_W-1:0] edit_addr;
  logic [DATA_W-1:0] edit_data;

  modport master (
    output edit_valid,
    output edit_addr,
    output edit_data,
    input  edit_ready
  );

  modport slave (
    input  edit_valid,
    input  edit_addr,
    input  edit_data,
    output edit_ready
  );
endinterface

// File: rtl/voxel_edit_scheduler.sv
// Queues host voxel edits and replays them into the shared voxel memory write port
// between frames; the world generator always wins the port.
module voxel_edit_scheduler #(
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 64,
  parameter int FIFO_DEPTH     = 16,
  parameter bit DRAIN_IN_FRAME = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        soft_reset,
  voxel_edit_scheduler_if.slave       edit,
  input  logic                        gen_wen,
  input  logic [ADDR_W-1:0]           gen_addr,
  input  logic [DATA_W-1:0]           gen_data,
  input  logic                        core_busy,
  output logic                        frame_hold,
  output logic                        mem_wen,
  output logic [ADDR_W-1:0]           mem_waddr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [15:0]                 edits_applied
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t              state_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [ADDR_W-1:0]   fifo_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_r [FIFO_DEPTH];
  logic                mem_wen_r;
  logic [ADDR_W-1:0]   mem_waddr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [15:0]         applied_r;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic hold_s;

  // Handshake, pop qualification and frame-start hold decode
  always_comb begin
    full_s  = (count_r == FULL_CNT);
    empty_s = (count_r == {CNT_W{1'b0}});
    push_s  = edit.edit_valid & ~full_s;
    pop_s   = (state_r == ST_DRAIN) & ~gen_wen & ~empty_s;
    if (DRAIN_IN_FRAME) begin
      hold_s = 1'b0;
    end else begin
      hold_s = (state_r == ST_DRAIN) | (~empty_s & ~core_busy);
    end
  end

  assign edit.edit_ready = ~full_s;
  assign frame_hold      = hold_s;
  assign mem_wen         = mem_wen_r;
  assign mem_waddr       = mem_waddr_r;
  assign mem_wdata       = mem_wdata_r;
  assign fifo_count      = count_r;
  assign edits_applied   = applied_r;

  // Drain sequencer: leaves IDLE only between frames unless in-frame draining is enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else if (soft_reset) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s && (!core_busy || DRAIN_IN_FRAME)) state_r <= ST_DRAIN;
          else state_r <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (pop_s && !push_s && (count_r == CNT_W'(1))) state_r <= ST_IDLE;
          else state_r <= ST_DRAIN;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (soft_reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Edit storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= edit.edit_addr;
      fifo_data_r[wr_ptr_r] <= edit.edit_data;
    end
  end

  // Registered write port: generator first, then FIFO head; address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wen_r   <= 1'b0;
      mem_waddr_r <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      applied_r   <= 16'h0000;
    end else if (soft_reset) begin
      mem_wen_r   <= 1'b0;
      mem_waddr_r <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      applied_r   <= 16'h0000;
    end else begin
      if (gen_wen) begin
        mem_wen_r   <= 1'b1;
        mem_waddr_r <= gen_addr;
        mem_wdata_r <= gen_data;
      end else if (pop_s) begin
        mem_wen_r   <= 1'b1;
        mem_waddr_r <= fifo_addr_r[rd_ptr_r];
        mem_wdata_r <= fifo_data_r[rd_ptr_r];
      end else begin
        mem_wen_r <= 1'b0;
      end
      if (pop_s) applied_r <= applied_r + 16'h0001;
    end
  end
endmodule

// File: tb/tb_voxel_edit_scheduler.sv
// Scoreboard bench: a queue-based reference model predicts every cycle's outputs, a monitor
// compares them; a second instance with in-frame draining covers the 16-bit counter wrap.
module tb_voxel_edit_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        soft_reset, gen_wen, core_busy;
  logic [17:0] gen_addr;
  logic [63:0] gen_data;
  logic        frame_hold, mem_wen;
  logic [17:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [4:0]  fifo_count;
  logic [15:0] edits_applied;

  logic        frame_hold2, mem_wen2;
  logic [17:0] mem_waddr2;
  logic [63:0] mem_wdata2;
  logic [4:0]  fifo_count2;
  logic [15:0] edits_applied2;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  voxel_edit_scheduler_if #(.ADDR_W(18), .DATA_W(64)) ifc ();
  voxel_edit_scheduler_if #(.ADDR_W(18), .DATA_W(64)) ifc2 ();

  voxel_edit_scheduler #(.ADDR_W(18), .DATA_W(64), .FIFO_DEPTH(16), .DRAIN_IN_FRAME(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .soft_reset(soft_reset), .edit(ifc),
    .gen_wen(gen_wen), .gen_addr(gen_addr), .gen_data(gen_data), .core_busy(core_busy),
    .frame_hold(frame_hold), .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .fifo_count(fifo_count), .edits_applied(edits_applied)
  );

  voxel_edit_scheduler #(.ADDR_W(18), .DATA_W(64), .FIFO_DEPTH(16), .DRAIN_IN_FRAME(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .soft_reset(1'b0), .edit(ifc2),
    .gen_wen(1'b0), .gen_addr(18'h00000), .gen_data(64'h0), .core_busy(1'b1),
    .frame_hold(frame_hold2), .mem_wen(mem_wen2), .mem_waddr(mem_waddr2), .mem_wdata(mem_wdata2),
    .fifo_count(fifo_count2), .edits_applied(edits_applied2)
  );

  typedef struct packed { logic [17:0] a; logic [63:0] d; } ent_t;
  typedef struct {
    logic        wen;
    logic [17:0] addr;
    logic [63:0] data;
    int          count;
    logic [15:0] applied;
    logic        ready;
    logic        hold;
  } exp_t;

  // Reference model state: pending edits, whether a drain pass is in progress
  ent_t        m_q[$];
  bit          m_drain   = 1'b0;
  logic [15:0] m_applied = 16'h0000;
  logic [17:0] m_addr    = 18'h00000;
  logic [63:0] m_data    = 64'h0;
  exp_t        exp_q[$];

  bit   mon2_en   = 1'b0;
  int   wr_idx2   = 0;
  int   hold_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model advances with the DUT and queues its prediction
  task automatic cycle(input bit v, input logic [17:0] a, input logic [63:0] d,
                       input bit g, input bit busy, input bit sr, output bit acc);
    logic [17:0] ga;
    logic [63:0] gd;
    exp_t        e;
    bit          pop;
    int          sz0;
    ga = 18'($urandom);
    gd = {$urandom, $urandom};
    @(negedge clk);
    ifc.edit_valid = v;
    ifc.edit_addr  = a;
    ifc.edit_data  = d;
    gen_wen        = g;
    gen_addr       = ga;
    gen_data       = gd;
    core_busy      = busy;
    soft_reset     = sr;
    @(posedge clk);
    acc = 1'b0;
    if (sr) begin
      m_q.delete();
      m_drain   = 1'b0;
      m_applied = 16'h0000;
      m_addr    = 18'h00000;
      m_data    = 64'h0;
      e.wen     = 1'b0;
    end else begin
      sz0   = m_q.size();
      pop   = m_drain && !g && (sz0 > 0);
      e.wen = g || pop;
      if (g) begin
        m_addr = ga;
        m_data = gd;
      end else if (pop) begin
        m_addr = m_q[0].a;
        m_data = m_q[0].d;
      end
      if (pop) begin
        void'(m_q.pop_front());
        m_applied = m_applied + 16'h0001;
      end
      if (v && (sz0 != 16)) begin
        m_q.push_back({a, d});
        acc = 1'b1;
      end
      if (!m_drain) m_drain = (sz0 != 0) && !busy;
      else m_drain = (m_q.size() != 0);
    end
    e.addr    = m_addr;
    e.data    = m_data;
    e.count   = m_q.size();
    e.applied = m_applied;
    e.ready   = (m_q.size() != 16);
    e.hold    = m_drain || ((m_q.size() != 0) && !busy);
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit busy);
    bit acc;
    cycle(1'b0, 18'($urandom), {$urandom, $urandom}, 1'b0, busy, 1'b0, acc);
  endtask

  task automatic push(input logic [17:0] a, input logic [63:0] d, input bit busy);
    bit acc;
    cycle(1'b1, a, d, 1'b0, busy, 1'b0, acc);
  endtask

  task automatic main_seq();
    bit acc;
    bit busy;
    int k;
    int guard;
    push(18'h00123, 64'hA5, 1'b0);
    repeat (6) idle(1'b0);
    for (int i = 0; i < 3; i++) push(18'(16'h0200 + i), 64'(32'hC0DE_0000 + i), 1'b1);
    repeat (3) idle(1'b1);
    repeat (8) idle(1'b0);
    k = 0;
    guard = 0;
    while (k < 17 && guard < 60) begin
      busy = (guard < 25);
      cycle(1'b1, 18'(32'h300 + k), 64'(k), 1'b0, busy, 1'b0, acc);
      if (acc) k++;
      guard++;
    end
    chk("full_fifo_all_17_accepted", 64'(k), 64'd17);
    repeat (25) idle(1'b0);
    for (int i = 0; i < 4; i++) push(18'(32'h400 + i), 64'(32'hBEEF_0000 + i), 1'b1);
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 18'h00000, 64'h0, (i == 2) || (i == 4), 1'b0, 1'b0, acc);
    for (int i = 0; i < 5; i++) push(18'(32'h500 + i), 64'(32'hFACE_0000 + i), 1'b1);
    repeat (3) idle(1'b0);
    cycle(1'b0, 18'h00000, 64'h0, 1'b0, 1'b0, 1'b1, acc);
    repeat (4) idle(1'b0);
    busy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19, 0) == 0) busy = ~busy;
      cycle(1'($urandom), 18'($urandom), {$urandom, $urandom}, $urandom_range(4, 0) == 0,
            busy, $urandom_range(99, 0) == 0, acc);
    end
    repeat (40) idle(1'b0);
  endtask

  // In-frame drain instance: 65537 edits streamed with the core permanently busy
  task automatic dif_seq();
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < 65537 && cyc < 70000) begin
      @(negedge clk);
      ifc2.edit_valid = 1'b1;
      ifc2.edit_addr  = 18'(idx);
      ifc2.edit_data  = 64'(idx);
      if (ifc2.edit_ready) idx++;
      cyc++;
    end
    @(negedge clk);
    ifc2.edit_valid = 1'b0;
    cyc = 0;
    while (wr_idx2 < 65537 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("dif_all_edits_written", 64'(wr_idx2), 64'd65537);
    chk("dif_edits_applied_wrap", 64'(edits_applied2), 64'h0001);
    chk("dif_fifo_empty", 64'(fifo_count2), 64'd0);
    chk("dif_frame_hold_never", 64'(hold_seen), 64'd0);
  endtask

  // Scoreboard monitor for the main instance
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mem_wen", 64'(mem_wen), 64'(e.wen));
        chk("mem_waddr", 64'(mem_waddr), 64'(e.addr));
        chk("mem_wdata", mem_wdata, e.data);
        chk("fifo_count", 64'(fifo_count), 64'(e.count));
        chk("edits_applied", 64'(edits_applied), 64'(e.applied));
        chk("edit_ready", 64'(ifc.edit_ready), 64'(e.ready));
        chk("frame_hold", 64'(frame_hold), 64'(e.hold));
      end
    end
  end

  // Write-order monitor for the in-frame drain instance
  initial begin : monitor2
    forever begin
      @(posedge clk);
      #1;
      if (mon2_en) begin
        if (mem_wen2) begin
          chk("dif_write_order", mem_wdata2, 64'(wr_idx2));
          wr_idx2++;
        end
        if (frame_hold2) hold_seen++;
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    soft_reset      = 1'b0;
    gen_wen         = 1'b0;
    gen_addr        = 18'h00000;
    gen_data        = 64'h0;
    core_busy       = 1'b0;
    ifc.edit_valid  = 1'b0;
    ifc.edit_addr   = 18'h00000;
    ifc.edit_data   = 64'h0;
    ifc2.edit_valid = 1'b0;
    ifc2.edit_addr  = 18'h00000;
    ifc2.edit_data  = 64'h0;
    #12;
    chk("reset_mem_wen", 64'(mem_wen), 64'd0);
    chk("reset_mem_waddr", 64'(mem_waddr), 64'd0);
    chk("reset_mem_wdata", mem_wdata, 64'd0);
    chk("reset_fifo_count", 64'(fifo_count), 64'd0);
    chk("reset_edits_applied", 64'(edits_applied), 64'd0);
    chk("reset_edit_ready", 64'(ifc.edit_ready), 64'd1);
    chk("reset_frame_hold", 64'(frame_hold), 64'd0);
    chk("reset_dif_edit_ready", 64'(ifc2.edit_ready), 64'd1);
    @(negedge clk);
    rst_n   = 1'b1;
    mon2_en = 1'b1;
    fork
      main_seq();
      dif_seq();
    join
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
